// File: rtl/audio_pkg.sv
// Shared I2S frame geometry and the stereo slot type used by the transmitter.
package audio_pkg;

    localparam int unsigned FRAME_BITS = 64;
    localparam int unsigned SLOT_BITS  = 32;
    localparam int unsigned LRCK_SPLIT = 32;
    localparam int unsigned BIT_CNT_W  = $clog2(FRAME_BITS);

    typedef struct packed {
        logic [SLOT_BITS-1:0] left;
        logic [SLOT_BITS-1:0] right;
    } stereo_sample_t;

endpackage

// File: rtl/audio_sample_fifo.sv
// Synchronous FIFO for stereo samples with registered occupancy.
module audio_sample_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      level_q;
    logic             do_push, do_pop;

    assign full    = (level_q == (AW+1)'(DEPTH));
    assign empty   = (level_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr_q];
    assign level   = level_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      level_q <= level_q + 1'b1;
            else if (do_pop && !do_push) level_q <= level_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/audio_i2s_tx.sv
// I2S transmitter: lock-gated BCLK/LRCK generation and MSB-first serialisation of
// one stereo frame per 64 BCLKs, fed from a small sample FIFO.
module audio_i2s_tx
    import audio_pkg::*;
#(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned BCLK_DIV   = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          pll_locked,
    input  logic                          enable,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [DATA_W-1:0]             s_left,
    input  logic [DATA_W-1:0]             s_right,
    output logic                          aud_bclk,
    output logic                          aud_daclrck,
    output logic                          aud_dacdat,
    output logic                          frame_tick,
    output logic                          underflow,
    input  logic                          clr_underflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned DIV_W = $clog2(BCLK_DIV);
    localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [DIV_W-1:0]     DIV_RISE = DIV_W'(BCLK_DIV / 2 - 1);
    localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(FRAME_BITS - 1);
    localparam logic [BIT_CNT_W-1:0] LRCK_AT  = BIT_CNT_W'(LRCK_SPLIT);

    logic                    lock_meta_q, lock_sync_q;
    logic                    run, fall, load;
    logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
    logic [BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_d, bit_next;
    logic [FRAME_BITS-1:0]   shreg_q, shreg_d;
    logic                    bclk_q, bclk_d, lrck_q, lrck_d, dat_q, dat_d;
    logic                    tick_q, tick_d, underflow_q, underflow_d;
    logic [2*DATA_W-1:0]     fifo_rdata;
    logic                    fifo_full, fifo_empty;
    stereo_sample_t          frame_word;

    audio_sample_fifo #(
        .WIDTH (2 * DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (s_valid),
        .wdata ({s_left, s_right}),
        .pop   (load),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // pll_locked comes from the PLL's own timing domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
        end else begin
            lock_meta_q <= pll_locked;
            lock_sync_q <= lock_meta_q;
        end
    end

    assign run      = enable & lock_sync_q;
    assign fall     = run && (div_cnt_q == DIV_LAST);
    assign bit_next = bit_cnt_q + BIT_CNT_W'(1);
    assign load     = fall && (bit_next == '0);

    always_comb begin
        frame_word.left  = SLOT_BITS'(fifo_rdata[2*DATA_W-1:DATA_W]) << (SLOT_BITS - DATA_W);
        frame_word.right = SLOT_BITS'(fifo_rdata[DATA_W-1:0]) << (SLOT_BITS - DATA_W);
        if (fifo_empty) frame_word = '0;
    end

    always_comb begin
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        bclk_d    = bclk_q;
        lrck_d    = lrck_q;
        dat_d     = dat_q;
        tick_d    = 1'b0;
        if (!run) begin
            div_cnt_d = DIV_LAST;
            bit_cnt_d = BIT_LAST;
            bclk_d    = 1'b0;
            lrck_d    = 1'b0;
            dat_d     = 1'b0;
        end else if (fall) begin
            div_cnt_d = '0;
            bit_cnt_d = bit_next;
            bclk_d    = 1'b0;
            lrck_d    = (bit_next >= LRCK_AT);
            if (load) begin
                // Bit 0 carries the I2S one-bit delay, so the word's MSB goes out next.
                shreg_d = frame_word;
                dat_d   = 1'b0;
                tick_d  = 1'b1;
            end else begin
                dat_d   = shreg_q[FRAME_BITS-1];
                shreg_d = shreg_q << 1;
            end
        end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
            if (div_cnt_q == DIV_RISE) bclk_d = 1'b1;
        end
    end

    always_comb begin
        underflow_d = underflow_q;
        if (clr_underflow)      underflow_d = 1'b0;
        if (load && fifo_empty) underflow_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q   <= DIV_LAST;
            bit_cnt_q   <= BIT_LAST;
            shreg_q     <= '0;
            bclk_q      <= 1'b0;
            lrck_q      <= 1'b0;
            dat_q       <= 1'b0;
            tick_q      <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            bclk_q      <= bclk_d;
            lrck_q      <= lrck_d;
            dat_q       <= dat_d;
            tick_q      <= tick_d;
            underflow_q <= underflow_d;
        end
    end

    assign s_ready     = ~fifo_full;
    assign aud_bclk    = bclk_q;
    assign aud_daclrck = lrck_q;
    assign aud_dacdat  = dat_q;
    assign frame_tick  = tick_q;
    assign underflow   = underflow_q;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Directed bench for audio_i2s_tx: a driver queues expected frame words on accepted
// pushes; a monitor reassembles each transmitted frame and compares it.
module tb_audio_i2s_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pll_locked = 1'b0;
    logic        enable = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] s_left = '0;
    logic [15:0] s_right = '0;
    logic        aud_bclk, aud_daclrck, aud_dacdat, frame_tick, underflow;
    logic        clr_underflow = 1'b0;
    logic [2:0]  fifo_level;

    audio_i2s_tx #(
        .DATA_W     (16),
        .BCLK_DIV   (4),
        .FIFO_DEPTH (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pll_locked    (pll_locked),
        .enable        (enable),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_left        (s_left),
        .s_right       (s_right),
        .aud_bclk      (aud_bclk),
        .aud_daclrck   (aud_daclrck),
        .aud_dacdat    (aud_dacdat),
        .frame_tick    (frame_tick),
        .underflow     (underflow),
        .clr_underflow (clr_underflow),
        .fifo_level    (fifo_level)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          frames_done = 0;
    logic [63:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] mk_word(input logic [15:0] l, input logic [15:0] r);
        return {l, 16'h0000, r, 16'h0000};
    endfunction

    // Monitor: bclk is low for the first half of each 4-clk bit slot; a broken
    // pattern means the frame was abandoned and its sample is lost.
    int          mon_cnt = 0;
    bit          in_frame = 1'b0;
    logic [63:0] data_vec, lrck_vec, exp_word;

    always @(negedge clk) begin
        if (rst) begin
            in_frame = 1'b0;
        end else begin
            if (frame_tick) begin
                in_frame = 1'b1;
                mon_cnt  = 0;
                data_vec = '0;
                lrck_vec = '0;
                if (exp_q.size() > 0) exp_word = exp_q.pop_front();
                else exp_word = '0;
            end
            if (in_frame) begin
                if (aud_bclk !== ((mon_cnt % 4) >= 2)) begin
                    in_frame = 1'b0;
                end else begin
                    if ((mon_cnt % 4) == 0) begin
                        data_vec = {data_vec[62:0], aud_dacdat};
                        lrck_vec = {lrck_vec[62:0], aud_daclrck};
                    end
                    if (mon_cnt == 252) begin
                        check("frame_data", data_vec, exp_word >> 1);
                        check("frame_lrck", lrck_vec, 64'h0000_0000_FFFF_FFFF);
                        frames_done++;
                        in_frame = 1'b0;
                    end
                    mon_cnt++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Caller is at a negedge; returns at the following negedge with s_valid low.
    task automatic push_one(input logic [15:0] l, input logic [15:0] r, output bit acc);
        s_valid = 1'b1;
        s_left  = l;
        s_right = r;
        acc     = s_ready;
        @(posedge clk);
        if (acc) exp_q.push_back(mk_word(l, r));
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic wait_tick(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!frame_tick && lat < 600);
    endtask

    task automatic wait_frames(input int target);
        int n = 0;
        while (frames_done < target && n < 1200) begin
            @(negedge clk);
            n++;
        end
        check("frames_reached", 64'(frames_done >= target), 64'd1);
    endtask

    task automatic check_idle(input string name);
        check({name, "_pins"}, 64'({aud_bclk, aud_daclrck, aud_dacdat, frame_tick, underflow}), 64'd0);
        check({name, "_ready"}, 64'(s_ready), 64'd1);
        check({name, "_level"}, 64'(fifo_level), 64'd0);
    endtask

    initial begin
        bit acc;
        int lat, base, acc_cnt, r1, r2;
        logic prev;

        repeat (3) @(negedge clk);
        check_idle("por");
        rst = 1'b0;

        // 1: reset in the middle of a frame
        push_one(16'h1234, 16'h5678, acc);
        enable = 1'b1;
        pll_locked = 1'b1;
        wait_tick(lat);
        repeat (20) @(negedge clk);
        #2 rst = 1'b1;
        enable = 1'b0;
        pll_locked = 1'b0;
        #1 check_idle("reset_mid");
        exp_q.delete();
        @(negedge clk);
        check_idle("reset_held");
        rst = 1'b0;
        @(negedge clk);

        // 2: one sample, lock rises with enable already high
        push_one(16'hA5A5, 16'h5A5A, acc);
        check("t2_level", 64'(fifo_level), 64'd1);
        enable = 1'b1;
        base = frames_done;
        pll_locked = 1'b1;
        wait_tick(lat);
        check("t2_lock_latency", 64'(lat), 64'd3);
        r1 = -1;
        r2 = -1;
        prev = aud_bclk;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (aud_bclk && !prev) begin
                if (r1 < 0) r1 = i;
                else if (r2 < 0) r2 = i;
            end
            prev = aud_bclk;
        end
        check("t2_bclk_period", 64'(r2 - r1), 64'd4);
        wait_frames(base + 1);
        enable = 1'b0;
        check("t2_frame_bits", data_vec, 64'h52D2_8000_2D2D_0000);
        check("t2_no_underflow", 64'(underflow), 64'd0);
        check("t2_level_after", 64'(fifo_level), 64'd0);
        repeat (4) @(negedge clk);

        // 3: underflow from an empty FIFO, clear, and set-beats-clear
        base = frames_done;
        enable = 1'b1;
        wait_tick(lat);
        check("t3_tick_latency", 64'(lat), 64'd1);
        check("t3_underflow_set", 64'(underflow), 64'd1);
        repeat (20) @(negedge clk);
        clr_underflow = 1'b1;
        @(negedge clk);
        clr_underflow = 1'b0;
        check("t3_underflow_clr", 64'(underflow), 64'd0);
        clr_underflow = 1'b1;
        wait_tick(lat);
        check("t3_set_wins", 64'(underflow), 64'd1);
        clr_underflow = 1'b0;
        enable = 1'b0;
        check("t3_frames", 64'(frames_done - base), 64'd1);
        repeat (4) @(negedge clk);

        // 4: fill with run=0, fifth push refused, one load frees a slot
        acc_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            push_one(16'(16'h1111 * (2 * i + 1)), 16'(16'h1111 * (2 * i + 2)), acc);
            if (acc) acc_cnt++;
        end
        check("t4_accepted", 64'(acc_cnt), 64'd4);
        check("t4_ready_full", 64'(s_ready), 64'd0);
        check("t4_level_full", 64'(fifo_level), 64'd4);
        enable = 1'b1;
        wait_tick(lat);
        check("t4_tick", 64'(frame_tick), 64'd1);
        check("t4_level_pop", 64'(fifo_level), 64'd3);
        check("t4_ready_pop", 64'(s_ready), 64'd1);

        // 5: lock lost at bit 10, relock resumes with the next queued sample
        repeat (41) @(negedge clk);
        pll_locked = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_pins_quiet", 64'({aud_bclk, aud_daclrck, aud_dacdat, frame_tick}), 64'd0);
        repeat (10) @(negedge clk);
        check("t5_level_kept", 64'(fifo_level), 64'd3);
        base = frames_done;
        pll_locked = 1'b1;
        wait_tick(lat);
        check("t5_relock_latency", 64'(lat), 64'd3);
        wait_frames(base + 3);
        enable = 1'b0;
        check("t5_level_drained", 64'(fifo_level), 64'd0);
        repeat (4) @(negedge clk);

        // 6: push lands in the same cycle as the frame-load pop
        push_one(16'hC3C3, 16'h3C3C, acc);
        check("t6_level_one", 64'(fifo_level), 64'd1);
        base = frames_done;
        enable  = 1'b1;
        s_valid = 1'b1;
        s_left  = 16'hBEEF;
        s_right = 16'hCAFE;
        acc     = s_ready;
        @(posedge clk);
        if (acc) exp_q.push_back(mk_word(16'hBEEF, 16'hCAFE));
        @(negedge clk);
        s_valid = 1'b0;
        check("t6_tick", 64'(frame_tick), 64'd1);
        check("t6_level_same", 64'(fifo_level), 64'd1);
        wait_frames(base + 2);
        enable = 1'b0;
        check("t6_frames", 64'(frames_done - base), 64'd2);
        check("t6_level_end", 64'(fifo_level), 64'd0);
        check("t6_queue_empty", 64'(exp_q.size()), 64'd0);
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
